// File: rtl/taxi_axis_xgmii_tx.sv
`default_nettype none
// ============================================================================
// taxi_axis_xgmii_tx : AXI-Stream to 64-bit XGMII transmit framer
// Revision 1.0 - initial release
// ============================================================================
module taxi_axis_xgmii_tx #(
  parameter int DATA_W     = 64,
  parameter int CTRL_W     = DATA_W / 8,
  parameter int USER_W     = 2,
  parameter int IFG_CYCLES = 1
) (
  input  logic              tx_clk,
  input  logic              tx_rst,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [CTRL_W-1:0] s_axis_tkeep,
  input  logic [USER_W-1:0] s_axis_tuser,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] xgmii_txd,
  output logic [CTRL_W-1:0] xgmii_txc,
  output logic              stat_tx_frame,
  output logic              stat_tx_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    TERM  = 3'd3,
    ERR   = 3'd4,
    DROP  = 3'd5,
    IFG   = 3'd6
  } state_t;

  localparam logic [DATA_W-1:0] c_idle_word  = {CTRL_W{8'h07}};
  localparam logic [DATA_W-1:0] c_err_word   = {CTRL_W{8'hFE}};
  localparam logic [DATA_W-1:0] c_term_word  = {{(CTRL_W-1){8'h07}}, 8'hFD};
  localparam logic [DATA_W-1:0] c_start_word = {8'hD5, {(CTRL_W-2){8'h55}}, 8'hFB};
  localparam logic [CTRL_W-1:0] c_all_ctrl   = {CTRL_W{1'b1}};
  localparam logic [CTRL_W-1:0] c_start_ctrl = {{(CTRL_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]        c_ifg_last   = 4'(IFG_CYCLES - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   txd_q, txd_d;
  logic [CTRL_W-1:0]   txc_q, txc_d;
  logic                tready_q, tready_d;
  logic                frame_q, frame_d;
  logic                err_q, err_d;
  logic                bad_q, bad_d;
  logic [3:0]          ifg_cnt_q, ifg_cnt_d;

  logic [DATA_W-1:0]   last_txd;
  logic [CTRL_W-1:0]   last_txc;
  logic [CTRL_W-1:0]   prev_keep;
  logic                unused_user;

  assign unused_user = ^s_axis_tuser;

  // Terminate lands in the first empty lane: the lane whose lower neighbour is still valid.
  assign prev_keep = {s_axis_tkeep[CTRL_W-2:0], 1'b1};

  always_comb begin
    last_txd = '0;
    last_txc = '0;
    for (int i = 0; i < CTRL_W; i++) begin
      if (s_axis_tkeep[i]) begin
        last_txd[i*8 +: 8] = s_axis_tdata[i*8 +: 8];
        last_txc[i]        = 1'b0;
      end else if (prev_keep[i]) begin
        last_txd[i*8 +: 8] = 8'hFD;
        last_txc[i]        = 1'b1;
      end else begin
        last_txd[i*8 +: 8] = 8'h07;
        last_txc[i]        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    txd_d     = c_idle_word;
    txc_d     = c_all_ctrl;
    frame_d   = 1'b0;
    err_d     = 1'b0;
    bad_d     = bad_q;
    ifg_cnt_d = ifg_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_axis_tvalid) state_d = START;
      end
      START: begin
        txd_d   = c_start_word;
        txc_d   = c_start_ctrl;
        bad_d   = 1'b0;
        state_d = DATA;
      end
      DATA: begin
        if (!s_axis_tvalid) begin
          txd_d   = c_err_word;
          err_d   = 1'b1;
          state_d = ERR;
        end else if (!s_axis_tlast) begin
          txd_d = s_axis_tdata;
          txc_d = '0;
        end else if (s_axis_tuser[0]) begin
          txd_d   = c_err_word;
          err_d   = 1'b1;
          bad_d   = 1'b1;
          state_d = TERM;
        end else if (&s_axis_tkeep) begin
          txd_d   = s_axis_tdata;
          txc_d   = '0;
          state_d = TERM;
        end else begin
          txd_d     = last_txd;
          txc_d     = last_txc;
          frame_d   = 1'b1;
          ifg_cnt_d = c_ifg_last;
          state_d   = IFG;
        end
      end
      TERM: begin
        txd_d     = c_term_word;
        frame_d   = !bad_q;
        ifg_cnt_d = c_ifg_last;
        state_d   = IFG;
      end
      ERR: begin
        txd_d   = c_term_word;
        state_d = DROP;
      end
      DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          ifg_cnt_d = c_ifg_last;
          state_d   = IFG;
        end
      end
      IFG: begin
        // A pending frame starts straight from the last gap cycle so the wire
        // shows exactly IFG_CYCLES idle words between terminate and start.
        if (ifg_cnt_q == 4'd0) begin
          state_d = s_axis_tvalid ? START : IDLE;
        end else begin
          ifg_cnt_d = ifg_cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    tready_d = (state_d == DATA) || (state_d == DROP);
  end

  always_ff @(posedge tx_clk) begin
    if (!tx_rst) begin
      state_q   <= IDLE;
      txd_q     <= c_idle_word;
      txc_q     <= c_all_ctrl;
      tready_q  <= 1'b0;
      frame_q   <= 1'b0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
      ifg_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      txc_q     <= txc_d;
      tready_q  <= tready_d;
      frame_q   <= frame_d;
      err_q     <= err_d;
      bad_q     <= bad_d;
      ifg_cnt_q <= ifg_cnt_d;
    end
  end

  assign s_axis_tready = tready_q;
  assign xgmii_txd     = txd_q;
  assign xgmii_txc     = txc_q;
  assign stat_tx_frame = frame_q;
  assign stat_tx_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_taxi_axis_xgmii_tx.sv
`default_nettype none
// ============================================================================
// tb_taxi_axis_xgmii_tx : directed self-checking bench for the XGMII TX framer
// Revision 1.0 - initial release
// ============================================================================
module tb_taxi_axis_xgmii_tx;

  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W  = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W   = 64'hFEFEFEFEFEFEFEFE;

  logic        tx_clk;
  logic        tx_rst;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic [1:0]  s_axis_tuser;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        stat_tx_frame;
  logic        stat_tx_err;

  int tests = 0;
  int fails = 0;

  taxi_axis_xgmii_tx #(
    .DATA_W     (64),
    .CTRL_W     (8),
    .USER_W     (2),
    .IFG_CYCLES (3)
  ) dut (
    .tx_clk        (tx_clk),
    .tx_rst        (tx_rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .xgmii_txd     (xgmii_txd),
    .xgmii_txc     (xgmii_txc),
    .stat_tx_frame (stat_tx_frame),
    .stat_tx_err   (stat_tx_err)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic u);
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = {1'b0, u};
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [63:0] d, input logic [7:0] c,
                            input logic rdy, input logic frm, input logic err);
    chk({tag, " txd"},   xgmii_txd, d);
    chk({tag, " txc"},   {56'd0, xgmii_txc}, {56'd0, c});
    chk({tag, " tready"}, {63'd0, s_axis_tready}, {63'd0, rdy});
    chk({tag, " frame"},  {63'd0, stat_tx_frame}, {63'd0, frm});
    chk({tag, " err"},    {63'd0, stat_tx_err},   {63'd0, err});
  endtask

  initial begin
    tx_rst = 1'b0;
    drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    expect_out("reset", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tx_rst = 1'b1;
    tick();
    expect_out("post_reset", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);

    // 16-byte frame, two full beats, TERM cycle follows
    drive(1'b1, 64'h0706050403020100, 8'hFF, 1'b0, 1'b0);
    tick(); expect_out("f16 idle",  IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("f16 start", START_W, 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("f16 d0", 64'h0706050403020100, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h0F0E0D0C0B0A0908, 8'hFF, 1'b1, 1'b0);
    tick(); expect_out("f16 d1", 64'h0F0E0D0C0B0A0908, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    tick(); expect_out("f16 term", TERM_W, 8'hFF, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("f16 ifg0", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("f16 ifg1", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("f16 ifg2", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);

    // 13-byte frame, terminate inside the last word
    drive(1'b1, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 1'b0);
    tick(); expect_out("f13 idle",  IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("f13 start", START_W, 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("f13 d0", 64'h0123456789ABCDEF, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h8877665544332211, 8'h1F, 1'b1, 1'b0);
    tick(); expect_out("f13 last", 64'h0707FD5544332211, 8'hE0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    tick(); expect_out("f13 ifg0", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("f13 ifg1", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("f13 ifg2", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);

    // underrun after first of four beats
    drive(1'b1, 64'h1010101010101010, 8'hFF, 1'b0, 1'b0);
    tick(); expect_out("urun idle",  IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("urun start", START_W, 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("urun d0", 64'h1010101010101010, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    tick(); expect_out("urun errw", ERR_W,  8'hFF, 1'b0, 1'b0, 1'b1);
    tick(); expect_out("urun term", TERM_W, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h2020202020202020, 8'hFF, 1'b0, 1'b0);
    tick(); expect_out("urun drop1", IDLE_W, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h3030303030303030, 8'hFF, 1'b0, 1'b0);
    tick(); expect_out("urun drop2", IDLE_W, 8'hFF, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'h4040404040404040, 8'h0F, 1'b1, 1'b0);
    tick(); expect_out("urun drop3", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    tick(); expect_out("urun ifg0", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("urun ifg1", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("urun ifg2", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);

    // single-beat frame flagged bad through tuser[0]
    drive(1'b1, 64'h5A5A5A5A5A5A5A5A, 8'h0F, 1'b1, 1'b1);
    tick(); expect_out("bad idle",  IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("bad start", START_W, 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("bad errw",  ERR_W,   8'hFF, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    tick(); expect_out("bad term",  TERM_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("bad ifg0",  IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("bad ifg1",  IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("bad ifg2",  IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);

    // back-to-back frames, tvalid held; second frame has tkeep=0 on its last beat
    drive(1'b1, 64'hA1A2A3A4A5A6A7A8, 8'hFF, 1'b1, 1'b0);
    tick(); expect_out("b2b idle",  IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("b2b start", START_W, 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("b2b a0", 64'hA1A2A3A4A5A6A7A8, 8'h00, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 64'hB1B2B3B4B5B6B7B8, 8'h00, 1'b1, 1'b0);
    tick(); expect_out("b2b term",   TERM_W,  8'hFF, 1'b0, 1'b1, 1'b0);
    tick(); expect_out("b2b gap0",   IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("b2b gap1",   IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("b2b gap2",   IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("b2b start2", START_W, 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("b2b keep0",  64'h07070707070707FD, 8'hFF, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    tick(); expect_out("b2b ifg0", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("b2b ifg1", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("b2b ifg2", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);

    // reset asserted in the middle of a frame
    drive(1'b1, 64'hC0C0C0C0C0C0C0C0, 8'hFF, 1'b0, 1'b0);
    tick(); expect_out("rmid idle",  IDLE_W,  8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("rmid start", START_W, 8'h01, 1'b1, 1'b0, 1'b0);
    tick(); expect_out("rmid d0", 64'hC0C0C0C0C0C0C0C0, 8'h00, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 64'hC1C1C1C1C1C1C1C1, 8'hFF, 1'b0, 1'b0);
    tx_rst = 1'b0;
    tick(); expect_out("rmid rst",   IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tx_rst = 1'b1;
    drive(1'b0, 64'd0, 8'h00, 1'b0, 1'b0);
    tick(); expect_out("rmid after0", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);
    tick(); expect_out("rmid after1", IDLE_W, 8'hFF, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
